// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus-level constants and the target state encoding.
package i2c_pkg;

  localparam int   BIT_CNT_W = 3;
  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_WAIT,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for one open-drain line, with registered rise/fall
// detect. level_o is aligned with the edge pulses.
module i2c_line_sync (
  input  logic clock_i,
  input  logic reset_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, rise_q, fall_q;

  // Idle bus level is high, so reset to 1 to avoid a phantom edge.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// Byte-level I2C target: fixed 7-bit address, write delivery via strobe,
// read data via request/valid with SCL stretching while data is pending.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS = 7'b1101000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       scl_in_i,
  input  logic       sda_in_i,
  output logic       scl_drive_low_o,
  output logic       sda_drive_low_o,
  output logic       selected_o,
  output logic       read_write_o,
  output logic [7:0] write_data_o,
  output logic       write_strobe_o,
  output logic       read_request_o,
  input  logic [7:0] read_data_i,
  input  logic       read_valid_i,
  output logic       stop_seen_o
);

  logic [1:0] raw, level, rise, fall;
  assign raw = {sda_in_i, scl_in_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    i2c_line_sync u_sync (
      .clock_i(clock_i), .reset_i(reset_i), .line_i(raw[gi]),
      .level_o(level[gi]), .rise_o(rise[gi]), .fall_o(fall[gi])
    );
  end

  logic scl_level, scl_rise, scl_fall, sda_level, start_det, stop_det;
  assign scl_level = level[0];
  assign scl_rise  = rise[0];
  assign scl_fall  = fall[0];
  assign sda_level = level[1];
  assign start_det = fall[1] & scl_level;
  assign stop_det  = rise[1] & scl_level;

  i2c_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]           shift_q, shift_d, wdata_q, wdata_d;
  logic sda_low_q, sda_low_d, scl_low_q, scl_low_d, selected_q, selected_d;
  logic rw_q, rw_d, wstrobe_q, wstrobe_d, rreq_q, rreq_d, stop_q, stop_d;
  logic loaded_q, loaded_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= 8'h00;
      wdata_q    <= 8'h00;
      sda_low_q  <= 1'b0;
      scl_low_q  <= 1'b0;
      selected_q <= 1'b0;
      rw_q       <= 1'b0;
      wstrobe_q  <= 1'b0;
      rreq_q     <= 1'b0;
      stop_q     <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wdata_q    <= wdata_d;
      sda_low_q  <= sda_low_d;
      scl_low_q  <= scl_low_d;
      selected_q <= selected_d;
      rw_q       <= rw_d;
      wstrobe_q  <= wstrobe_d;
      rreq_q     <= rreq_d;
      stop_q     <= stop_d;
      loaded_q   <= loaded_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    wdata_d    = wdata_q;
    sda_low_d  = sda_low_q;
    scl_low_d  = scl_low_q;
    selected_d = selected_q;
    rw_d       = rw_q;
    wstrobe_d  = 1'b0;
    rreq_d     = 1'b0;
    stop_d     = 1'b0;
    loaded_d   = loaded_q;
    if (stop_det || start_det) begin
      state_d    = stop_det ? IDLE : ADDR;
      stop_d     = stop_det;
      cnt_d      = '0;
      sda_low_d  = 1'b0;
      scl_low_d  = 1'b0;
      selected_d = 1'b0;
      loaded_d   = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, WR_BYTE: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_level};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 3'd7) begin
            if (state_q == WR_BYTE) begin
              wdata_d   = {shift_q[6:0], sda_level};
              wstrobe_d = 1'b1;
              state_d   = WR_ACK;
            end else if (shift_q[6:0] == ADDRESS) begin
              rw_d    = sda_level;
              state_d = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // sda_low_q doubles as the phase flag: first fall drives, second releases.
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!sda_low_q) begin
            sda_low_d  = 1'b1;
            selected_d = 1'b1;
          end else begin
            sda_low_d = 1'b0;
            cnt_d     = '0;
            if (state_q == WR_ACK || !rw_q) begin
              state_d = WR_BYTE;
            end else begin
              state_d   = RD_WAIT;
              scl_low_d = 1'b1;
              rreq_d    = 1'b1;
              loaded_d  = 1'b0;
            end
          end
        end
        RD_WAIT: begin
          if (loaded_q) begin
            scl_low_d = 1'b0;
            cnt_d     = '0;
            state_d   = RD_BYTE;
          end else if (read_valid_i) begin
            shift_d   = read_data_i;
            sda_low_d = ~read_data_i[7];
            loaded_d  = 1'b1;
          end
        end
        RD_BYTE: if (scl_fall) begin
          if (cnt_q == 3'd7) begin
            sda_low_d = 1'b0;
            state_d   = RD_ACK;
          end else begin
            sda_low_d = ~shift_q[6];
            shift_d   = {shift_q[6:0], 1'b0};
            cnt_d     = cnt_q + 1'b1;
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_level == I2C_NACK) begin
            state_d = IGNORE;
          end else if (scl_fall) begin
            state_d   = RD_WAIT;
            scl_low_d = 1'b1;
            rreq_d    = 1'b1;
            loaded_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // A bus condition lets go of SCL immediately rather than a cycle later.
  assign scl_drive_low_o = scl_low_q & ~(start_det | stop_det);
  assign sda_drive_low_o = sda_low_q;
  assign selected_o      = selected_q;
  assign read_write_o    = rw_q;
  assign write_data_o    = wdata_q;
  assign write_strobe_o  = wstrobe_q;
  assign read_request_o  = rreq_q;
  assign stop_seen_o     = stop_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-level controller model on an
// open-drain bus, a host read-data responder and event monitors.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic scl_ctl = 1'b1, sda_ctl = 1'b1;
  logic scl_bus, sda_bus;
  logic scl_drive_low, sda_drive_low, selected, read_write;
  logic write_strobe, read_request, stop_seen;
  logic [7:0] write_data;
  logic [7:0] read_data = 8'h00;
  logic read_valid = 1'b0;

  assign scl_bus = scl_ctl & ~scl_drive_low;
  assign sda_bus = sda_ctl & ~sda_drive_low;

  i2c_target dut (
    .clock_i(clock), .reset_i(reset), .scl_in_i(scl_bus), .sda_in_i(sda_bus),
    .scl_drive_low_o(scl_drive_low), .sda_drive_low_o(sda_drive_low),
    .selected_o(selected), .read_write_o(read_write),
    .write_data_o(write_data), .write_strobe_o(write_strobe),
    .read_request_o(read_request), .read_data_i(read_data),
    .read_valid_i(read_valid), .stop_seen_o(stop_seen)
  );

  int n_checks = 0, n_pass = 0;
  int wr_cnt = 0, stop_cnt = 0, rreq_cnt = 0, stretch_run = 0, stretch_max = 0;
  int host_delay = 0;
  logic sda_low_seen = 1'b0, sel_seen = 1'b0, sda_at_release = 1'b0;
  logic [7:0] wr_log[$];
  logic [7:0] host_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  always @(negedge clock) begin
    if (write_strobe) begin wr_cnt++; wr_log.push_back(write_data); end
    if (stop_seen) stop_cnt++;
    if (read_request) rreq_cnt++;
    if (sda_drive_low) sda_low_seen = 1'b1;
    if (selected) sel_seen = 1'b1;
    if (scl_drive_low) begin
      stretch_run++;
      sda_at_release = sda_drive_low;
      if (stretch_run > stretch_max) stretch_max = stretch_run;
    end else begin
      stretch_run = 0;
    end
  end

  initial forever begin
    @(negedge clock);
    if (read_request) begin
      repeat (host_delay) @(negedge clock);
      read_valid = 1'b1;
      read_data  = (host_q.size() > 0) ? host_q.pop_front() : 8'hee;
      @(negedge clock);
      read_valid = 1'b0;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic scl_high();
    int n = 0;
    scl_ctl = 1'b1;
    while (!scl_bus && n < 5000) begin @(negedge clock); n++; end
    if (!scl_bus) check("scl_release_timeout", 0, 1);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_ctl = b;
    wait_clk(Q);
    scl_high();
    wait_clk(Q);
    s = sda_bus;
    wait_clk(Q);
    scl_ctl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic start_cond();
    sda_ctl = 1'b1; wait_clk(Q);
    scl_high();     wait_clk(Q);
    sda_ctl = 1'b0; wait_clk(Q);
    scl_ctl = 1'b0; wait_clk(Q);
  endtask

  task automatic stop_cond();
    sda_ctl = 1'b0; wait_clk(Q);
    scl_high();     wait_clk(Q);
    sda_ctl = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] v);
    logic s;
    logic [7:0] t = 8'h00;
    for (int i = 7; i >= 0; i--) begin bit_xfer(1'b1, s); t[i] = s; end
    bit_xfer(ack_bit, s);
    v = t;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic ack, s;
    logic [7:0] v;

    // Reset state
    wait_clk(5);
    check("rst_scl", scl_drive_low, 0);
    check("rst_sda", sda_drive_low, 0);
    check("rst_selected", selected, 0);
    check("rst_rw", read_write, 0);
    check("rst_wdata", write_data, 8'h00);
    check("rst_wstrobe", write_strobe, 0);
    check("rst_rreq", read_request, 0);
    check("rst_stop", stop_seen, 0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    wait_clk(10);

    // Write 0x68 W: 00 0f aa, STOP
    start_cond();
    write_byte(8'hd0, ack); check("wr_addr_ack", ack, 0);
    check("wr_selected", selected, 1);
    check("wr_rw", read_write, 0);
    write_byte(8'h00, ack); check("wr_b0_ack", ack, 0);
    write_byte(8'h0f, ack); check("wr_b1_ack", ack, 0);
    write_byte(8'haa, ack); check("wr_b2_ack", ack, 0);
    stop_cond();
    check("wr_strobes", wr_cnt, 3);
    check("wr_data0", wr_log[0], 8'h00);
    check("wr_data1", wr_log[1], 8'h0f);
    check("wr_data2", wr_log[2], 8'haa);
    check("wr_stops", stop_cnt, 1);
    check("wr_sel_after_stop", selected, 0);

    // Foreign address 0x50 W
    wr_cnt = 0; sda_low_seen = 1'b0; sel_seen = 1'b0;
    start_cond();
    write_byte(8'ha0, ack); check("na_addr_nack", ack, 1);
    write_byte(8'h55, ack); check("na_byte_nack", ack, 1);
    stop_cond();
    check("na_sda_driven", sda_low_seen, 0);
    check("na_selected", sel_seen, 0);
    check("na_strobes", wr_cnt, 0);

    // Write then repeated START read of two bytes
    wr_cnt = 0; rreq_cnt = 0; host_delay = 0;
    host_q.push_back(8'h5a); host_q.push_back(8'hc3);
    start_cond();
    write_byte(8'hd0, ack); check("rd_waddr_ack", ack, 0);
    write_byte(8'h00, ack); check("rd_wbyte_ack", ack, 0);
    start_cond();
    write_byte(8'hd1, ack); check("rd_raddr_ack", ack, 0);
    check("rd_rw", read_write, 1);
    read_byte(1'b0, v); check("rd_byte0", v, 8'h5a);
    read_byte(1'b1, v); check("rd_byte1", v, 8'hc3);
    check("rd_state_ignore", 32'(dut.state_q), 32'(IGNORE));
    check("rd_requests", rreq_cnt, 2);
    stop_cond();

    // Slow host: 50-cycle stretch, bit 7 on SDA before SCL release
    host_delay = 50; stretch_max = 0; sda_at_release = 1'b0;
    host_q.push_back(8'h3c);
    start_cond();
    write_byte(8'hd1, ack); check("st_addr_ack", ack, 0);
    read_byte(1'b1, v); check("st_byte", v, 8'h3c);
    check("st_stretch_ge50", 32'(stretch_max >= 50), 1);
    check("st_bit7_before_release", sda_at_release, 1);
    stop_cond();
    host_delay = 0;

    // STOP after 4 data bits
    wr_cnt = 0; stop_cnt = 0;
    start_cond();
    write_byte(8'hd0, ack); check("sp_addr_ack", ack, 0);
    bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b0, s);
    stop_cond();
    check("sp_strobes", wr_cnt, 0);
    check("sp_stops", stop_cnt, 1);
    check("sp_sda", sda_drive_low, 0);
    check("sp_scl", scl_drive_low, 0);
    check("sp_state_idle", 32'(dut.state_q), 32'(IDLE));

    // Reset mid-read while SDA is driven low
    host_q.push_back(8'h00);
    start_cond();
    write_byte(8'hd1, ack); check("mr_addr_ack", ack, 0);
    for (int n = 0; n < 100 && !sda_drive_low; n++) @(negedge clock);
    check("mr_sda_driven", sda_drive_low, 1);
    reset = 1'b1;
    @(negedge clock);
    check("mr_sda_released", sda_drive_low, 0);
    check("mr_scl_released", scl_drive_low, 0);
    scl_ctl = 1'b1; sda_ctl = 1'b1;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(20);
    start_cond();
    write_byte(8'hd0, ack); check("mr_post_addr_ack", ack, 0);
    write_byte(8'h12, ack); check("mr_post_byte_ack", ack, 0);
    stop_cond();
    check("mr_post_wdata", write_data, 8'h12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

Byte-level I2C target (slave) responder, the bus-side counterpart to `i2c_controller`. It watches SCL/SDA and detects START, repeated START and STOP. It matches a fixed 7-bit address, ACKs and delivers written bytes to the host logic, and serves read bytes through a request/valid handshake. SCL is stretched while it waits for read data. It sits behind the open-drain pad logic, which is shared with the controller in the peripheral I/O block.

## Interface
- `ADDRESS`, 7'b1101000: 7-bit address this target answers to.
- `clock` in 1: system clock; must be at least 10× the SCL frequency.
- `reset` in 1: synchronous, active-high.
- `scl_in` in 1: raw SCL pad level (asynchronous).
- `sda_in` in 1: raw SDA pad level (asynchronous).
- `scl_drive_low` out 1: 1 pulls SCL low (clock stretch); 0 releases it.
- `sda_drive_low` out 1: 1 pulls SDA low; 0 releases it.
- `selected` out 1: high from address ACK until the next START or STOP.
- `read_write` out 1: R/W bit of the current addressed transfer (1 = read).
- `write_data` out 8: last byte written by the controller.
- `write_strobe` out 1: one-cycle pulse when `write_data` is valid.
- `read_request` out 1: one-cycle pulse when the next read byte is needed.
- `read_data` in 8: byte to transmit; sampled when `read_valid` is high.
- `read_valid` in 1: read_data is valid; accepted only while the stretch is active.
- `stop_seen` out 1: one-cycle pulse on STOP, whether or not the target is addressed.

## Operation
- SCL/SDA pass through a 2-flop synchroniser. Edges are detected on the synchronised values.
- START: synchronised SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- START and STOP are honoured in every state and take priority over bit handling.
- States:
  - IDLE: lines released; waits for START.
  - ADDR: shifts 8 bits MSB first on SCL rising edges.
  - ADDR_ACK
  - WR_BYTE
  - WR_ACK
  - RD_WAIT
  - RD_BYTE
  - RD_ACK
  - IGNORE
- START from any state → ADDR; bit counter cleared; `selected` cleared.
- STOP from any state → IDLE; `stop_seen` pulses.
- ADDR, after the 8th rising edge:
  - Address match → ADDR_ACK and latch `read_write`.
  - Mismatch → IGNORE: no line is driven until START or STOP.
- ADDR_ACK:
  - On the SCL falling edge after the 8th bit, assert `sda_drive_low` and set `selected`.
  - Release SDA on the next (9th) falling edge.
  - Then → WR_BYTE if writing, or RD_WAIT if reading.
- WR_BYTE: shift 8 bits on rising edges.
  - After the 8th bit, `write_data` updates and `write_strobe` pulses one cycle.
  - Then → WR_ACK. The target always ACKs.
- WR_ACK: same SDA timing as ADDR_ACK, then → WR_BYTE.
- RD_WAIT:
  - On entry, pulse `read_request` and assert `scl_drive_low`.
  - On the first cycle `read_valid` is high, latch `read_data`.
  - On that same cycle, drive bit 7 onto SDA (drive low if the bit is 0).
  - Release SCL the following cycle → RD_BYTE.
- RD_BYTE: on each SCL falling edge, present the next bit. After the 8th falling edge, release SDA → RD_ACK.
- RD_ACK: sample SDA on the 9th rising edge.
  - Low (ACK) → RD_WAIT at the 9th falling edge.
  - High (NACK) → IGNORE.
- SDA is only ever changed while synchronised SCL is low.

## Timing
- Reset values:
  - Both drive outputs 0.
  - `selected`, `read_write`, all strobes/pulses and `stop_seen` are 0.
  - `write_data` = 8'h00.
  - State IDLE.
- Reset mid-transfer releases both lines on the next clock.
- Latency from a pad edge to its internal edge detect: 3 clocks (2 sync stages plus the edge register).
- `write_strobe` fires 1 cycle after the detected 8th rising edge.
- RD_WAIT entry:
  - `scl_drive_low` rises on the cycle after the detected falling edge.
  - The controller already holds SCL low at that point, so the stretch is glitch-free.
- Minimum stretch: 1 cycle after `read_valid`.
- `read_valid` outside RD_WAIT is ignored.
- START arriving during RD_WAIT releases SCL in the same cycle it is detected.

## Structure
- Package `i2c_pkg`: state enum, `I2C_ACK`/`I2C_NACK` constants, bit-count width. The package is shared with `i2c_controller`.
- Sub-module `i2c_line_sync`: 2-flop synchroniser plus previous-value register, one per line. It outputs the level, rise and fall for that line.
- The core FSM, 3-bit bit counter and 8-bit shift register live in `i2c_target`.

## Test plan
- Controller writes address 0x68 W, then 0x00, 0x0f, 0xaa, then STOP → SDA held low on each 9th clock. `write_strobe` fires 3 times with `write_data` 0x00, 0x0f, 0xaa. `stop_seen` pulses once.
- Address 0x50 W plus one byte → `sda_drive_low` never asserted, `selected` stays 0, no `write_strobe`.
- Write 0x68 W with byte 0x00, repeated START, 0x68 R, host supplies 0x5a then 0xc3, controller ACKs then NACKs → SDA carries 01011010 then 11000011. `read_request` pulses 2 times. Target returns to IGNORE after the NACK.
- Host delays `read_valid` 50 cycles after `read_request` → `scl_drive_low` high for at least 50 cycles. The first bit appears on SDA before SCL is released.
- STOP injected after 4 bits of a write byte → no `write_strobe`, lines released, state IDLE.
- Reset asserted mid-read with SDA driven low → `sda_drive_low` and `scl_drive_low` are 0 the next cycle. A subsequent 0x68 W transfer ACKs normally.
